// File: rtl/key_event_decoder.sv
`default_nettype none
// key_event_decoder: turns debounced press/release pulses of one button into
// SINGLE/DOUBLE/LONG_START/REPEAT/LONG_END events plus the measured hold time.
module key_event_decoder #(
  parameter int TICK_DIV  = 24000,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_press,
  input  logic        key_release,
  output logic        evt_valid,
  output logic [2:0]  evt_code,
  output logic [15:0] hold_ms,
  output logic        key_busy
);

  localparam int            TW          = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [15:0]   LONG_LAST   = 16'(LONG_MS - 1);
  localparam logic [15:0]   DCLICK_LAST = 16'(DCLICK_MS - 1);
  localparam logic [15:0]   REPEAT_LAST = 16'(REPEAT_MS - 1);
  localparam logic [16:0]   LONG_BASE   = 17'(LONG_MS);
  localparam logic [15:0]   MS_MAX      = 16'hFFFF;

  localparam logic [2:0] EVT_NONE       = 3'd0;
  localparam logic [2:0] EVT_SINGLE     = 3'd1;
  localparam logic [2:0] EVT_DOUBLE     = 3'd2;
  localparam logic [2:0] EVT_LONG_START = 3'd3;
  localparam logic [2:0] EVT_REPEAT     = 3'd4;
  localparam logic [2:0] EVT_LONG_END   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [15:0]   ms_cnt;
  logic [15:0]   rep_cnt;
  logic          ms_tick;
  logic          long_hit;
  logic          dclick_hit;
  logic          repeat_hit;
  logic          timer_clear;
  logic [15:0]   ms_cnt_inc;
  logic [16:0]   long_sum;
  logic [15:0]   long_hold;
  logic          evt_valid_nxt;
  logic [2:0]    evt_code_nxt;
  logic          hold_load;
  logic [15:0]   hold_nxt;

  assign ms_tick    = (tick_cnt == TICK_LAST);
  // ms_cnt_inc already counts a tick landing in this cycle, so a release on a
  // tick edge reports the just-completed millisecond.
  assign ms_cnt_inc = (ms_tick && (ms_cnt != MS_MAX)) ? ms_cnt + 16'd1 : ms_cnt;
  assign long_hit   = ms_tick && (ms_cnt == LONG_LAST);
  assign dclick_hit = ms_tick && (ms_cnt == DCLICK_LAST);
  assign repeat_hit = ms_tick && (rep_cnt == REPEAT_LAST);

  // Timer restarts on entry to LONG, so the total hold adds back LONG_MS.
  assign long_sum   = {1'b0, ms_cnt_inc} + LONG_BASE;
  assign long_hold  = long_sum[16] ? MS_MAX : long_sum[15:0];

  assign timer_clear = (state_nxt != state) || (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    evt_valid_nxt = 1'b0;
    evt_code_nxt  = EVT_NONE;
    hold_load     = 1'b0;
    hold_nxt      = ms_cnt_inc;
    case (state)
      S_IDLE: begin
        if (key_press) begin
          state_nxt = S_PRESS1;
        end
      end
      S_PRESS1: begin
        if (key_release) begin
          state_nxt = S_WAIT2;
          hold_load = 1'b1;
        end else if (long_hit) begin
          state_nxt     = S_LONG;
          evt_valid_nxt = 1'b1;
          evt_code_nxt  = EVT_LONG_START;
        end
      end
      S_WAIT2: begin
        if (key_press) begin
          state_nxt = S_PRESS2;
        end else if (dclick_hit) begin
          state_nxt     = S_IDLE;
          evt_valid_nxt = 1'b1;
          evt_code_nxt  = EVT_SINGLE;
        end
      end
      S_PRESS2: begin
        if (key_release) begin
          state_nxt     = S_IDLE;
          evt_valid_nxt = 1'b1;
          evt_code_nxt  = EVT_DOUBLE;
          hold_load     = 1'b1;
        end else if (long_hit) begin
          state_nxt     = S_LONG;
          evt_valid_nxt = 1'b1;
          evt_code_nxt  = EVT_LONG_START;
        end
      end
      S_LONG: begin
        if (key_release) begin
          state_nxt     = S_IDLE;
          evt_valid_nxt = 1'b1;
          evt_code_nxt  = EVT_LONG_END;
          hold_load     = 1'b1;
          hold_nxt      = long_hold;
        end else if (repeat_hit) begin
          evt_valid_nxt = 1'b1;
          evt_code_nxt  = EVT_REPEAT;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
      rep_cnt  <= '0;
    end else if (timer_clear) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
      rep_cnt  <= '0;
    end else begin
      tick_cnt <= ms_tick ? '0 : tick_cnt + 1'b1;
      ms_cnt   <= ms_cnt_inc;
      if (ms_tick) begin
        rep_cnt <= (rep_cnt == REPEAT_LAST) ? 16'd0 : rep_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_code  <= EVT_NONE;
      hold_ms   <= 16'd0;
      key_busy  <= 1'b0;
    end else begin
      evt_valid <= evt_valid_nxt;
      evt_code  <= evt_code_nxt;
      key_busy  <= (state != S_IDLE);
      if (hold_load) begin
        hold_ms <= hold_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// tb_key_event_decoder: directed scenarios plus randomized pulses checked
// against a timestamp-based reference model of the button event rules.
module tb_key_event_decoder;

  localparam int TD = 4;
  localparam int LG = 10;
  localparam int DC = 5;
  localparam int RP = 3;

  localparam int M_IDLE = 0, M_P1 = 1, M_W2 = 2, M_P2 = 3, M_LONG = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_press;
  logic        key_release;
  logic        evt_valid;
  logic [2:0]  evt_code;
  logic [15:0] hold_ms;
  logic        key_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time in a mode is the cycle distance from entry.
  int       m_mode  = M_IDLE;
  int       m_entry = 0;
  int       m_cyc   = 0;
  int       m_hold  = 0;
  logic     exp_valid = 1'b0;
  logic [2:0] exp_code = 3'd0;
  logic     exp_busy = 1'b0;

  key_event_decoder #(
    .TICK_DIV (TD),
    .LONG_MS  (LG),
    .DCLICK_MS(DC),
    .REPEAT_MS(RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_press  (key_press),
    .key_release(key_release),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .hold_ms    (hold_ms),
    .key_busy   (key_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_hold    = 0;
    exp_valid = 1'b0;
    exp_code  = 3'd0;
    exp_busy  = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic r);
    int e, ms, ev;
    logic tk;
    e  = m_cyc - m_entry;
    tk = (e > 0) && (e % TD == 0);
    ms = e / TD;
    ev = 0;
    exp_busy = (m_mode != M_IDLE);
    case (m_mode)
      M_IDLE: if (p) begin m_mode = M_P1; m_entry = m_cyc; end
      M_P1: begin
        if (r) begin m_mode = M_W2; m_hold = ms; m_entry = m_cyc; end
        else if (tk && ms == LG) begin m_mode = M_LONG; ev = 3; m_entry = m_cyc; end
      end
      M_W2: begin
        if (p) begin m_mode = M_P2; m_entry = m_cyc; end
        else if (tk && ms == DC) begin m_mode = M_IDLE; ev = 1; m_entry = m_cyc; end
      end
      M_P2: begin
        if (r) begin m_mode = M_IDLE; ev = 2; m_hold = ms; m_entry = m_cyc; end
        else if (tk && ms == LG) begin m_mode = M_LONG; ev = 3; m_entry = m_cyc; end
      end
      default: begin
        if (r) begin
          m_mode = M_IDLE; ev = 5; m_entry = m_cyc;
          m_hold = (LG + ms > 65535) ? 65535 : LG + ms;
        end else if (tk && ms % RP == 0) begin
          ev = 4;
        end
      end
    endcase
    exp_valid = (ev != 0);
    exp_code  = 3'(ev);
    m_cyc++;
  endtask

  // Drives one cycle of input; on return the outputs of the next cycle are stable.
  task automatic cycle(input logic p, input logic r);
    @(negedge clk);
    key_press   = p;
    key_release = r;
    @(posedge clk);
    model_step(p, r);
    #1;
    key_press   = 1'b0;
    key_release = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_press = 1'b0; key_release = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if ({evt_valid, evt_code, hold_ms, key_busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0b code=%0d hold=%0d busy=%0b, want all 0",
               evt_valid, evt_code, hold_ms, key_busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0);
    n_tests++;
    if ({evt_valid, evt_code, hold_ms, key_busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got valid=%0b code=%0d hold=%0d busy=%0b, want all 0",
               evt_valid, evt_code, hold_ms, key_busy);
    end
  endtask

  task automatic test_single();
    int spurious = 0;
    for (int c = 0; c < 36; c++) begin
      cycle(c == 0, c == 12);
      if (c + 1 == 33) begin
        n_tests++;
        if ({evt_valid, evt_code, hold_ms} !== {1'b1, 3'd1, 16'd3}) begin
          n_fail++;
          $display("FAIL single_evt: got valid=%0b code=%0d hold=%0d, want 1/1/3",
                   evt_valid, evt_code, hold_ms);
        end
        n_tests++;
        if (key_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_busy33: got %0b, want 1", key_busy);
        end
      end else begin
        if (evt_valid !== 1'b0 || evt_code !== 3'd0) spurious++;
        if (c + 1 == 34) begin
          n_tests++;
          if (key_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy34: got %0b, want 0", key_busy);
          end
        end
      end
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL single_quiet: got %0d stray events, want 0", spurious);
    end
  endtask

  task automatic test_double();
    int spurious = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(c == 0 || c == 16, c == 8 || c == 28);
      if (c + 1 == 29) begin
        n_tests++;
        if ({evt_valid, evt_code, hold_ms} !== {1'b1, 3'd2, 16'd3}) begin
          n_fail++;
          $display("FAIL double_evt: got valid=%0b code=%0d hold=%0d, want 1/2/3",
                   evt_valid, evt_code, hold_ms);
        end
      end else if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin
        spurious++;
      end
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL double_quiet: got %0d stray events, want 0", spurious);
    end
  endtask

  task automatic test_long();
    int spurious = 0;
    logic [2:0] want;
    for (int c = 0; c < 76; c++) begin
      cycle(c == 0, c == 70);
      case (c + 1)
        41:      want = 3'd3;
        53, 65:  want = 3'd4;
        71:      want = 3'd5;
        default: want = 3'd0;
      endcase
      if (want != 3'd0) begin
        n_tests++;
        if ({evt_valid, evt_code} !== {1'b1, want}) begin
          n_fail++;
          $display("FAIL long_evt@%0d: got valid=%0b code=%0d, want 1/%0d",
                   c + 1, evt_valid, evt_code, want);
        end
      end else if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin
        spurious++;
      end
      if (c + 1 == 71) begin
        n_tests++;
        if (hold_ms !== 16'd17) begin
          n_fail++;
          $display("FAIL long_hold: got %0d, want 17", hold_ms);
        end
      end
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL long_quiet: got %0d stray events, want 0", spurious);
    end
  endtask

  task automatic test_race_wait2_press();
    int spurious = 0;
    for (int c = 0; c < 46; c++) begin
      cycle(c == 0 || c == 32, c == 12 || c == 36);
      if (c + 1 == 37) begin
        n_tests++;
        if ({evt_valid, evt_code, hold_ms} !== {1'b1, 3'd2, 16'd1}) begin
          n_fail++;
          $display("FAIL race_w2_evt: got valid=%0b code=%0d hold=%0d, want 1/2/1",
                   evt_valid, evt_code, hold_ms);
        end
      end else if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin
        spurious++;
      end
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL race_w2_quiet: got %0d stray events, want 0", spurious);
    end
  endtask

  task automatic test_race_long_release();
    int spurious = 0;
    for (int c = 0; c < 66; c++) begin
      cycle(c == 0, c == 40);
      if (c + 1 == 61) begin
        n_tests++;
        if ({evt_valid, evt_code, hold_ms} !== {1'b1, 3'd1, 16'd10}) begin
          n_fail++;
          $display("FAIL race_long_evt: got valid=%0b code=%0d hold=%0d, want 1/1/10",
                   evt_valid, evt_code, hold_ms);
        end
      end else if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin
        spurious++;
      end
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL race_long_quiet: got %0d stray events, want 0", spurious);
    end
  endtask

  task automatic test_illegal();
    int spurious = 0;
    for (int c = 0; c < 36; c++) begin
      cycle(c == 2 || c == 5, c == 0 || c == 2 || c == 10);
      if (c + 1 == 2 || c + 1 == 4) begin
        n_tests++;
        if (key_busy !== (c + 1 == 4)) begin
          n_fail++;
          $display("FAIL illegal_busy@%0d: got %0b, want %0b", c + 1, key_busy, (c + 1 == 4));
        end
      end
      if (c + 1 == 31) begin
        n_tests++;
        if ({evt_valid, evt_code, hold_ms} !== {1'b1, 3'd1, 16'd2}) begin
          n_fail++;
          $display("FAIL illegal_evt: got valid=%0b code=%0d hold=%0d, want 1/1/2",
                   evt_valid, evt_code, hold_ms);
        end
      end else if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin
        spurious++;
      end
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL illegal_quiet: got %0d stray events, want 0", spurious);
    end
  endtask

  task automatic test_reset_mid_long();
    int spurious = 0;
    for (int c = 0; c < 50; c++) cycle(c == 0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({evt_valid, evt_code, hold_ms, key_busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL midreset_out: got valid=%0b code=%0d hold=%0d busy=%0b, want all 0",
               evt_valid, evt_code, hold_ms, key_busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 33; c++) begin
      cycle(c == 3, c == 0 || c == 7);
      if (c + 1 == 28) begin
        n_tests++;
        if ({evt_valid, evt_code, hold_ms} !== {1'b1, 3'd1, 16'd1}) begin
          n_fail++;
          $display("FAIL midreset_click: got valid=%0b code=%0d hold=%0d, want 1/1/1",
                   evt_valid, evt_code, hold_ms);
        end
      end else if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin
        spurious++;
      end
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got %0d stray events, want 0", spurious);
    end
  endtask

  task automatic test_random();
    int rate;
    logic p, r;
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(2))
        0:       rate = 4;
        1:       rate = 15;
        default: rate = 50;
      endcase
      for (int c = 0; c < 100; c++) begin
        p = ($urandom_range(rate - 1) == 0);
        r = ($urandom_range(rate - 1) == 0);
        cycle(p, r);
        n_tests++;
        if ({evt_valid, evt_code, hold_ms, key_busy} !==
            {exp_valid, exp_code, 16'(m_hold), exp_busy}) begin
          n_fail++;
          $display("FAIL random@%0d: got valid=%0b code=%0d hold=%0d busy=%0b, want %0b/%0d/%0d/%0b",
                   m_cyc, evt_valid, evt_code, hold_ms, key_busy,
                   exp_valid, exp_code, m_hold, exp_busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_long();
    test_race_wait2_press();
    test_race_long_release();
    test_illegal();
    test_reset_mid_long();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
